// File: rtl/program_loader.sv
// program_loader
//
// Loads a program image from a byte-wide valid/ready stream into the
// instruction memory write port. The CPU is held in reset until the whole
// image has been written.
//
// Stream format: 16-bit word count (high byte first), followed by that many
// big-endian 32-bit words.
//
// Optional feature (macro PROGRAM_LOADER_CHECKSUM_EN):
//   After the data, one extra byte is expected. It must equal the XOR of
//   every preceding stream byte, including the header. A mismatch ends the
//   load in ERROR. Words already written stay in memory, but the CPU stays
//   in reset.
//
// Parameters
//   BASE_ADDR    byte address of the first word written
//   MAX_WORDS    instruction memory capacity in words; a larger count is an error
//
// Ports
//   clk_i        system clock; all state changes on the rising edge
//   reset_i      synchronous, active-high reset
//   start_i      begin a load (sampled in IDLE, DONE and ERROR only)
//   in_valid_i   source presents a byte on in_byte_i
//   in_byte_i    stream byte
//   in_ready_o   loader accepts a byte this cycle (depends on state only)
//   mem_wrt_o    one-cycle instruction memory write strobe
//   mem_addr_o   word-aligned byte address of the write
//   mem_din_o    write data
//   busy_o       load in progress
//   done_o       image loaded successfully
//   error_o      load aborted
//   cpu_reset_o  CPU reset; low only after a successful load
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_byte_i,
  output logic        in_ready_o,
  output logic        mem_wrt_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_din_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        cpu_reset_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHK    = 3'd4,
`endif
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  // State that follows the last data byte (or an empty header).
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CHK;
`else
  localparam state_t END_ST = DONE;
`endif

  // Control registers
  state_t      state_q,     state_d;
  logic [15:0] idx_q,       idx_d;
  logic [1:0]  bcnt_q,      bcnt_d;
  logic        mem_wrt_q,   mem_wrt_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_din_q,   mem_din_d;
  logic        cpu_reset_q, cpu_reset_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q,      csum_d;
`endif

  // Data registers (no reset needed: always loaded before use)
  logic [15:0] count_q,     count_d;
  logic [23:0] word_q,      word_d;

  logic        accept;
  logic [15:0] hdr_count;

  // The ready signal is a pure function of the state register.
  always_comb begin
    in_ready_o = 1'b0;
    case (state_q)
      HDR_HI, HDR_LO, DATA: in_ready_o = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHK:                  in_ready_o = 1'b1;
`endif
      default:              in_ready_o = 1'b0;
    endcase
  end

  assign accept      = in_valid_i && in_ready_o;
  assign hdr_count   = {count_q[15:8], in_byte_i};
  assign busy_o      = in_ready_o;
  assign done_o      = (state_q == DONE);
  assign error_o     = (state_q == ERROR);
  assign mem_wrt_o   = mem_wrt_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_din_o   = mem_din_q;
  assign cpu_reset_o = cpu_reset_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    count_d    = count_q;
    word_d     = word_q;
    mem_wrt_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    if (accept && state_q != CHK) begin
      csum_d = csum_q ^ in_byte_i;
    end
`endif

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          state_d = HDR_HI;
          idx_d   = '0;
          bcnt_d  = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      HDR_HI: begin
        if (accept) begin
          count_d = {in_byte_i, count_q[7:0]};
          state_d = HDR_LO;
        end
      end

      HDR_LO: begin
        if (accept) begin
          count_d = hdr_count;
          if (hdr_count == 16'd0) begin
            state_d = END_ST;
          end else if (hdr_count > MAX_CNT) begin
            state_d = ERROR;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (accept) begin
          word_d = {word_q[15:0], in_byte_i};
          bcnt_d = bcnt_q + 2'd1;
          // Fourth byte of a word: the write is registered here and is
          // presented to memory during the following cycle.
          if (bcnt_q == 2'd3) begin
            mem_wrt_d  = 1'b1;
            mem_din_d  = {word_q, in_byte_i};
            mem_addr_d = BASE_ADDR + {14'd0, idx_q, 2'b00};
            idx_d      = idx_q + 16'd1;
            if (idx_q == count_q - 16'd1) begin
              state_d = END_ST;
            end
          end
        end
      end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_d = (in_byte_i == csum_q) ? DONE : ERROR;
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    // Release the CPU one cycle after DONE is entered, so the final write
    // lands first; reassert it on the edge that leaves DONE.
    cpu_reset_d = !(state_q == DONE && !start_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      bcnt_q      <= '0;
      mem_wrt_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      cpu_reset_q <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      mem_wrt_q   <= mem_wrt_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      cpu_reset_q <= cpu_reset_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
    word_q  <= word_d;
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  localparam int MAXW = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        mem_wrt;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_reset;

  program_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(MAXW)) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .start_i     (start),
    .in_valid_i  (in_valid),
    .in_byte_i   (in_byte),
    .in_ready_o  (in_ready),
    .mem_wrt_o   (mem_wrt),
    .mem_addr_o  (mem_addr),
    .mem_din_o   (mem_din),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .cpu_reset_o (cpu_reset)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int c0 = 0;
  int done_rise = -1;
  logic prev_wrt = 1'b0;
  logic prev_done = 1'b0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample outputs 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_wrt) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_din);
      wc.push_back(cyc);
      chk("wrt_single_cycle", 32'(prev_wrt), 32'd0);
    end
    if (done && !prev_done) begin
      done_rise = cyc;
      chk("cpu_rst_at_done_rise", 32'(cpu_reset), 32'd1);
    end
    if (done && prev_done && cyc == done_rise + 1)
      chk("cpu_rst_after_done", 32'(cpu_reset), 32'd0);
    if (done || error)
      chk("ready_when_finished", 32'(in_ready), 32'd0);
    prev_wrt  = mem_wrt;
    prev_done = done;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_mem_wrt"},   32'(mem_wrt),   32'd0);
    chk({tag, "_mem_addr"},  mem_addr,       32'd0);
    chk({tag, "_mem_din"},   mem_din,        32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_error"},     32'(error),     32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
  endtask

  task automatic start_load();
    wa.delete();
    wd.delete();
    wc.delete();
    done_rise = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    c0 = cyc;
    chk("busy_after_start",  32'(busy),     32'd1);
    chk("ready_after_start", 32'(in_ready), 32'd1);
  endtask

  // Offer the bytes in order; optional random gaps (with random start
  // pulses that the loader must ignore) and one fixed pause before byte
  // pause_at.
  task automatic send_bytes(input logic [7:0] s[$], input bit rnd,
                            input int pause_at, input int pause_len);
    int i;
    int budget;
    int paused;
    bit give;
    bit acc;
    i = 0;
    budget = 0;
    paused = 0;
    while (i < s.size() && budget < 4000) begin
      give = 1'b1;
      if (rnd && $urandom_range(0, 3) == 0) give = 1'b0;
      if (i == pause_at && paused < pause_len) begin
        give = 1'b0;
        paused++;
      end
      in_valid = give;
      in_byte  = give ? s[i] : 8'($urandom);
      if (rnd) start = 1'($urandom_range(0, 1));
      acc = give && in_ready;
      step();
      if (acc) i++;
      budget++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("stream_complete", 32'(i), 32'(s.size()));
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  // Reference model: expected writes and outcome derived from the stream.
  task automatic check_model(input logic [7:0] s[$], input string tag);
    int cnt;
    int nw;
    bit exp_err;
    logic [7:0] x;
    cnt = int'({s[0], s[1]});
    exp_err = (cnt > MAXW);
    nw = exp_err ? 0 : cnt;
    x = 8'h00;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (!exp_err) begin
      for (int k = 0; k < 2 + 4 * cnt; k++) x ^= s[k];
      exp_err = (s[2 + 4 * cnt] != x);
    end
`endif
    chk({tag, "_nwrites"}, 32'(wa.size()), 32'(nw));
    for (int k = 0; k < nw && k < int'(wa.size()); k++) begin
      chk({tag, "_addr"}, wa[k], 32'(4 * k));
      chk({tag, "_din"},  wd[k], {s[2 + 4 * k], s[3 + 4 * k], s[4 + 4 * k], s[5 + 4 * k]});
    end
    chk({tag, "_done"},      32'(done),      32'(!exp_err));
    chk({tag, "_error"},     32'(error),     32'(exp_err));
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(exp_err));
    chk({tag, "_busy"},      32'(busy),      32'd0);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
    if (!exp_err && nw > 0 && wc.size() > 0)
      chk({tag, "_done_with_last_wr"}, 32'(done_rise), 32'(wc[wc.size() - 1]));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] tp[$];
    logic [7:0] s[$];
    logic [7:0] x;
    logic [15:0] cnt;

    tp = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    tp.push_back(8'hD7);
`endif

    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_byte = 8'h00;
    step();
    step();
    check_reset_vals("reset");
    rst = 1'b0;
    step();

    // Test-plan stream, back to back
    start_load();
    send_bytes(tp, 1'b0, -1, 0);
    drain();
    chk("tp_wr0_cyc", 32'(wc.size() > 0 ? wc[0] - c0 : -1), 32'd6);
    chk("tp_wr1_cyc", 32'(wc.size() > 1 ? wc[1] - c0 : -1), 32'd10);
    check_model(tp, "tp");

    // Same stream, 3-cycle pause after 00 02 24 08
    start_load();
    send_bytes(tp, 1'b0, 4, 3);
    drain();
    chk("pause_wr0_cyc", 32'(wc.size() > 0 ? wc[0] - c0 : -1), 32'd9);
    chk("pause_wr1_cyc", 32'(wc.size() > 1 ? wc[1] - c0 : -1), 32'd13);
    check_model(tp, "pause");

    // Oversized header
    s = '{8'h00, 8'h41};
    start_load();
    send_bytes(s, 1'b0, -1, 0);
    chk("oversize_err_now",   32'(error),     32'd1);
    chk("oversize_ready",     32'(in_ready),  32'd0);
    chk("oversize_cpu_reset", 32'(cpu_reset), 32'd1);
    drain();
    check_model(s, "oversize");

    // Empty image
    s = '{8'h00, 8'h00};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    s.push_back(8'h00);
`endif
    start_load();
    send_bytes(s, 1'b0, -1, 0);
    chk("empty_done_now", 32'(done), 32'd1);
    drain();
    check_model(s, "empty");
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    s = '{8'h00, 8'h00, 8'h01};
    start_load();
    send_bytes(s, 1'b0, -1, 0);
    drain();
    check_model(s, "empty_badsum");

    // Bad checksum, then reload with the correct one
    s = tp;
    s[s.size() - 1] = 8'hD6;
    start_load();
    send_bytes(s, 1'b0, -1, 0);
    drain();
    check_model(s, "badsum");
    start_load();
    send_bytes(tp, 1'b0, -1, 0);
    drain();
    check_model(tp, "badsum_reload");
`endif

    // Reset in the middle of a load, then a full reload
    start_load();
    s = tp[0:5];
    send_bytes(s, 1'b0, -1, 0);
    rst = 1'b1;
    step();
    check_reset_vals("midreset");
    rst = 1'b0;
    step();
    check_reset_vals("midreset_idle");
    start_load();
    send_bytes(tp, 1'b0, -1, 0);
    drain();
    check_model(tp, "after_reset");

    // Randomized images with random gaps and ignored start pulses
    for (int t = 0; t < 14; t++) begin
      if (t == 0)      cnt = 16'd64;
      else if (t == 1) cnt = 16'd65;
      else if (t == 2) cnt = 16'h0100;
      else             cnt = 16'($urandom_range(0, 7));
      s.delete();
      s.push_back(cnt[15:8]);
      s.push_back(cnt[7:0]);
      if (int'(cnt) <= MAXW) begin
        repeat (4 * int'(cnt)) s.push_back(8'($urandom));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        x = 8'h00;
        foreach (s[k]) x ^= s[k];
        if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
        s.push_back(x);
`endif
      end
      start_load();
      send_bytes(s, 1'b1, -1, 0);
      drain();
      check_model(s, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
